// File: rtl/regfile_bypass.sv
// regfile_bypass: integer register file for the decode stage.
// Two read ports (rs1/rs2 decoded from the instruction) with one-cycle
// registered latency, one write port with write-to-read bypass, an optional
// hardwired-zero x0, and a hold control that freezes the operand outputs.
// After reset a clear sequencer walks every entry to zero before raising ready.
module regfile_bypass #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            rd_en,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rs1data,
  output logic [XLEN-1:0] rs2data,
  output logic            ready
);

  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Last index the clear sequencer touches before switching to RUN.
  localparam logic [AW-1:0] CLR_LAST = AW'(NREGS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];

  logic [0:0]      state_q,   state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q,   ready_d;
  logic [XLEN-1:0] rs1data_q, rs1data_d;
  logic [XLEN-1:0] rs2data_q, rs2data_d;

  // ---------------------------------------------------------------------------
  // Address decode helpers
  // ---------------------------------------------------------------------------
  // Addresses arrive as 5 bits regardless of NREGS; anything at or above
  // NREGS is treated as nonexistent before the low AW bits are used to index.
  function automatic logic addr_in_range(input logic [4:0] a);
    return (32'(a) < 32'(NREGS));
  endfunction

  // x0 is special only when the hardwired-zero option is enabled.
  function automatic logic addr_is_zero_reg(input logic [4:0] a);
    return (ZERO_REG != 0) && (a == 5'd0);
  endfunction

  // A write only lands (and only bypasses) when it targets a real,
  // writable register and the sequencer has handed over to normal operation.
  logic wr_addr_ok;
  logic wr_fire;

  assign wr_addr_ok = addr_in_range(waddr) && !addr_is_zero_reg(waddr);
  assign wr_fire    = wen && wr_addr_ok && (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [4:0]      rs_addr [2];
  logic [XLEN-1:0] rd_val  [2];

  assign rs_addr[0] = instr[19:15];
  assign rs_addr[1] = instr[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic          forced_zero;
      logic          bypass_hit;
      logic [AW-1:0] idx;

      // Out-of-range and hardwired-zero reads win over the bypass, so a write
      // to a dropped address can never leak into an operand.
      assign forced_zero = !addr_in_range(rs_addr[gi]) || addr_is_zero_reg(rs_addr[gi]);
      assign bypass_hit  = wen && wr_addr_ok && (waddr == rs_addr[gi]);
      assign idx         = rs_addr[gi][AW-1:0];

      assign rd_val[gi] = forced_zero ? '0 :
                          bypass_hit  ? wdata :
                                        regs_q[idx];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic for the sequencer and the operand registers
  // ---------------------------------------------------------------------------
  // Compute the sequencer advance and operand capture for the coming edge.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;

    case (state_q)
      ST_CLEAR: begin
        // Operands are parked at zero and inputs are ignored while clearing.
        rs1data_d = '0;
        rs2data_d = '0;
        if (clr_idx_q == CLR_LAST) begin
          state_d   = ST_RUN;
          ready_d   = 1'b1;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        // rd_en low is a stall: hold operands even if a write lands.
        if (rd_en) begin
          rs1data_d = rd_val[0];
          rs2data_d = rd_val[1];
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
        rs1data_d = '0;
        rs2data_d = '0;
      end
    endcase
  end

  // Register the sequencer and operand outputs; reset restarts clearing at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rs1data_q <= '0;
      rs2data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // Single write port shared by the clear sequencer and the architectural
  // write; contents are deliberately not reset so the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        regs_q[clr_idx_q] <= '0;
      end else if (wr_fire) begin
        regs_q[waddr[AW-1:0]] <= wdata;
      end
    end
  end

  assign rs1data = rs1data_q;
  assign rs2data = rs2data_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass. Three instances share one stimulus:
//   dut_a : NREGS=32, ZERO_REG=1
//   dut_b : NREGS=32, ZERO_REG=0
//   dut_c : NREGS=8,  ZERO_REG=1
module tb_regfile_bypass;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        rd_en;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2, c_rs1, c_rs2;
  logic        a_rdy, b_rdy, c_rdy;

  int n_total;
  int n_pass;

  regfile_bypass #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .rd_en(rd_en), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rs1data(a_rs1), .rs2data(a_rs2), .ready(a_rdy)
  );

  regfile_bypass #(.XLEN(32), .NREGS(32), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .rd_en(rd_en), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rs1data(b_rs1), .rs2data(b_rs2), .ready(b_rdy)
  );

  regfile_bypass #(.XLEN(32), .NREGS(8), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .instr(instr), .rd_en(rd_en), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rs1data(c_rs1), .rs2data(c_rs2), .ready(c_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 15'd0};
  endfunction

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst   = 1'b1;
    instr = mk_instr(5'd3, 5'd4);
    rd_en = 1'b1;
    wen   = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;

    // 1. Reset flow
    step();
    step();
    chk("rst_ready_a", 32'(a_rdy), 32'd0);
    chk("rst_rs1_a",   a_rs1, 32'd0);
    chk("rst_rs2_a",   a_rs2, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("clr_rdy_a%0d", k), 32'(a_rdy), (k >= 32) ? 32'd1 : 32'd0);
      chk($sformatf("clr_rs1_a%0d", k), a_rs1, 32'd0);
      if (k == 7 || k == 8)
        chk($sformatf("clr_rdy_c%0d", k), 32'(c_rdy), (k >= 8) ? 32'd1 : 32'd0);
    end
    chk("clr_rdy_b", 32'(b_rdy), 32'd1);
    for (int r = 0; r < 32; r++) begin
      instr = mk_instr(5'(r), 5'(31 - r));
      step();
      chk($sformatf("zero_a_rs1_%0d", r), a_rs1, 32'd0);
      chk($sformatf("zero_b_rs2_%0d", r), b_rs2, 32'd0);
    end

    // 2. Write then read
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; instr = mk_instr(5'd1, 5'd2);
    step();
    wen = 1'b0; instr = mk_instr(5'd5, 5'd0);
    step();
    chk("wr_rd_a_rs1", a_rs1, 32'hDEADBEEF);
    chk("wr_rd_a_rs2", a_rs2, 32'd0);
    chk("wr_rd_c_rs1", c_rs1, 32'hDEADBEEF);

    // 3. Bypass on both ports
    wen = 1'b1; waddr = 5'd7; wdata = 32'h0000_1234; instr = mk_instr(5'd7, 5'd7);
    step();
    chk("byp_a_rs1", a_rs1, 32'h0000_1234);
    chk("byp_a_rs2", a_rs2, 32'h0000_1234);
    wen = 1'b0;
    step();
    chk("byp_stored_a", a_rs1, 32'h0000_1234);

    // 4. Zero register (ZERO_REG=1 on a, 0 on b)
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; instr = mk_instr(5'd0, 5'd0);
    step();
    chk("x0_byp_a", a_rs1, 32'd0);
    chk("x0_byp_b", b_rs1, 32'hFFFFFFFF);
    wen = 1'b0;
    step();
    chk("x0_read_a", a_rs1, 32'd0);
    chk("x0_read_b", b_rs2, 32'hFFFFFFFF);

    // 5. Stall
    wen = 1'b1; waddr = 5'd10; wdata = 32'h0000_000A; instr = mk_instr(5'd1, 5'd1);
    step();
    wen = 1'b0; instr = mk_instr(5'd10, 5'd5);
    step();
    chk("stall_pre_rs1", a_rs1, 32'h0000_000A);
    chk("stall_pre_rs2", a_rs2, 32'hDEADBEEF);
    rd_en = 1'b0; wen = 1'b1; waddr = 5'd10; wdata = 32'h0000_000B; instr = mk_instr(5'd10, 5'd7);
    step();
    chk("stall_hold_rs1", a_rs1, 32'h0000_000A);
    chk("stall_hold_rs2", a_rs2, 32'hDEADBEEF);
    wen = 1'b0;
    step();
    chk("stall_hold2", a_rs1, 32'h0000_000A);
    rd_en = 1'b1;
    step();
    chk("stall_rel_rs1", a_rs1, 32'h0000_000B);
    chk("stall_rel_rs2", a_rs2, 32'h0000_1234);

    // 6. Range check on the 8-entry instance
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099; instr = mk_instr(5'd9, 5'd7);
    step();
    chk("range_byp_c", c_rs1, 32'd0);
    chk("range_x7_c",  c_rs2, 32'h0000_1234);
    chk("range_byp_a", a_rs1, 32'h0000_0099);
    wen = 1'b0; instr = mk_instr(5'd9, 5'd1);
    step();
    chk("range_rd_c", c_rs1, 32'd0);
    chk("range_rd_a", a_rs1, 32'h0000_0099);

    // Mid-operation reset; the write on the reset edge is discarded
    rst = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 32'h0000_0077; instr = mk_instr(5'd5, 5'd7);
    step();
    chk("mid_rst_rdy_a", 32'(a_rdy), 32'd0);
    chk("mid_rst_rdy_c", 32'(c_rdy), 32'd0);
    chk("mid_rst_rs1_a", a_rs1, 32'd0);
    chk("mid_rst_rs1_c", c_rs1, 32'd0);
    rst = 1'b0; wen = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 7 || k == 8)
        chk($sformatf("re_rdy_c%0d", k), 32'(c_rdy), (k >= 8) ? 32'd1 : 32'd0);
      if (k == 31 || k == 32)
        chk($sformatf("re_rdy_a%0d", k), 32'(a_rdy), (k >= 32) ? 32'd1 : 32'd0);
    end
    instr = mk_instr(5'd5, 5'd12);
    step();
    chk("re_x5_a",  a_rs1, 32'd0);
    chk("re_x12_a", a_rs2, 32'd0);
    chk("re_x5_c",  c_rs1, 32'd0);
    instr = mk_instr(5'd7, 5'd10);
    step();
    chk("re_x7_c",  c_rs1, 32'd0);
    chk("re_x10_b", b_rs2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
